dht11_frame_rx: RTL
===================

Name: dht11_frame_rx

Overview:
UART receive-side counterpart of the sensor telemetry link. It deserialises 8N1 bytes from a single rx line and reassembles 8-byte frames: sensor1 bytes 3..0 followed by sensor2 bytes 3..0, MSB byte first. It presents both 32-bit sensor words atomically with a one-cycle valid pulse. It is used on the host/bridge FPGA and as a loopback checker for the transmit path.

Parameters:
CLK_FREQ, 12000000, system clock in Hz
BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, 104 at defaults)
GAP_BITS, 20, max idle bit-times allowed between bytes inside a frame before the partial frame is dropped

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx  in  1  asynchronous UART line, idle high
sensor1_data  out  32  last complete frame, sensor1 word
sensor2_data  out  32  last complete frame, sensor2 word
frame_valid  out  1  one-cycle pulse, data words just updated
frame_error  out  1  one-cycle pulse, partial frame discarded
debug_state  out  3  current frame-FSM state encoding

Behaviour:
- Single clock. Reset is synchronous and active-high. Reset values: sensor words 0, frame_valid 0, frame_error 0, debug_state 0, byte index 0, synchroniser flops 1.
- rx passes through a 2-flop synchroniser. All decisions use the synchronised value.
- Byte receiver states: R_IDLE, R_START, R_DATA, R_STOP.
- R_IDLE → R_START on a synced high-to-low transition.
- R_START: wait CLKS_PER_BIT/2 clocks (52), then sample. If high, it is a glitch: return to R_IDLE with no pulse. If low, go to R_DATA.
- R_DATA: sample 8 bits, LSB first, each CLKS_PER_BIT clocks after the previous sample.
- R_STOP: sample after CLKS_PER_BIT clocks. If high, pulse byte_valid for one cycle with the byte. If low, pulse byte_err and discard the byte. Either way return to R_IDLE; a new start is only seen on a fresh falling edge.
- Frame FSM states: F_IDLE=0, F_COLLECT=1, F_ERROR=2.
  - byte_valid in F_IDLE stores byte 0 and moves to F_COLLECT with index=1.
  - Each byte_valid in F_COLLECT shifts the byte into a 64-bit assembly register and increments the index.
  - On the 8th byte: sensor1_data = assembly[63:32] and sensor2_data = assembly[31:0] are written together. frame_valid pulses on the next cycle after the 8th byte_valid (latency 1 clk). FSM returns to F_IDLE with index 0.
- Gap timer: counts clocks while in F_COLLECT and clears on every byte_valid. When it reaches GAP_BITS*CLKS_PER_BIT, enter F_ERROR.
- byte_err in any state enters F_ERROR.
- F_ERROR lasts exactly one cycle: frame_error=1, index cleared, assembly discarded, sensor words unchanged, then F_IDLE.
- If byte_valid and the gap timeout occur in the same cycle, byte_valid wins.
- Frames may arrive back-to-back with no idle gap.
- Outputs hold their values between frames. frame_valid and frame_error are never high in the same cycle.
- Reset asserted mid-byte or mid-frame aborts immediately to reset values. No pulse is generated.

Decomposition:
- Package dht11_pkg: frame-FSM and byte-FSM state localparams, FRAME_BYTES=8, a function computing CLKS_PER_BIT.
- Sub-module uart_rx (params CLK_FREQ, BAUD_RATE): owns the synchroniser and byte FSM. Outputs data[7:0], byte_valid, byte_err.
- dht11_frame_rx instantiates uart_rx and contains the frame FSM and gap timer.

Test Plan:
- Nominal frame: drive bytes 37 00 19 05 40 00 1A 03 at 104 clk/bit → sensor1_data=0x37001905, sensor2_data=0x40001A03, exactly one frame_valid pulse, 1 clk after the 8th stop-bit sample.
- Glitch: rx low for 30 clks then high → no byte_valid, no pulses, state stays 0.
- Stop-bit error: 3 good bytes, then a 4th byte with stop=0 → one frame_error pulse, words unchanged. A following full frame of 11 22 33 44 55 66 77 88 gives 0x11223344 / 0x55667788.
- Gap timeout: 5 bytes, then idle → frame_error exactly 2080 clks after the 5th byte_valid, index back to 0. The next full frame is accepted.
- Back-to-back: two frames with zero idle between them → two frame_valid pulses, second frame's words correct.
- Reset mid-frame: assert reset during the 6th byte → all outputs 0, no pulses. The next full frame is decoded correctly.

Source files
------------

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared state encodings, frame size and baud-divider helper for the telemetry receiver.
package dht11_pkg;
   localparam int FRAME_BYTES = 8;
   typedef enum logic [2:0] {F_IDLE = 3'd0, F_COLLECT = 3'd1, F_ERROR = 3'd2} frame_state_e;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} byte_state_e;
   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 byte receiver with 2-flop rx synchroniser; pulses byte_valid or byte_err after the stop sample.
module uart_rx
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ  = 12000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       byte_err
);
   localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   byte_state_e   state_q;
   logic          sync1_q, sync2_q, prev_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shreg_q, data_q;
   logic          valid_q, err_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= R_IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            R_IDLE: if (prev_q && !sync2_q) begin
               state_q <= R_START;
               cnt_q   <= '0;
            end
            R_START: if (cnt_q == CW'(HALF - 1)) begin
               cnt_q   <= '0;
               bit_q   <= '0;
               state_q <= sync2_q ? R_IDLE : R_DATA;
            end else cnt_q <= cnt_q + 1'b1;
            R_DATA: if (cnt_q == CW'(CPB - 1)) begin
               cnt_q   <= '0;
               shreg_q <= {sync2_q, shreg_q[7:1]};
               bit_q   <= bit_q + 3'd1;
               if (bit_q == 3'd7) state_q <= R_STOP;
            end else cnt_q <= cnt_q + 1'b1;
            R_STOP: if (cnt_q == CW'(CPB - 1)) begin
               cnt_q   <= '0;
               state_q <= R_IDLE;
               if (sync2_q) begin
                  data_q  <= shreg_q;
                  valid_q <= 1'b1;
               end else err_q <= 1'b1;
            end else cnt_q <= cnt_q + 1'b1;
            default: state_q <= R_IDLE;
         endcase
      end
   end
   assign data       = data_q;
   assign byte_valid = valid_q;
   assign byte_err   = err_q;
endmodule

// File: rtl/dht11_frame_rx.sv
// dht11_frame_rx: reassembles 8-byte UART frames into two 32-bit sensor words with valid/error pulses.
module dht11_frame_rx
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ  = 12000000,
   parameter int BAUD_RATE = 115200,
   parameter int GAP_BITS  = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic [31:0] sensor1_data,
   output logic [31:0] sensor2_data,
   output logic        frame_valid,
   output logic        frame_error,
   output logic [2:0]  debug_state
);
   localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int GAP_LIMIT = GAP_BITS * CPB;
   localparam int GW        = $clog2(GAP_LIMIT + 1);
   localparam int IW        = $clog2(FRAME_BYTES);
   logic [7:0]    rx_data;
   logic          byte_valid, byte_err;
   frame_state_e  state_q;
   logic [IW-1:0] idx_q;
   logic [GW-1:0] gap_q;
   logic [63:0]   asm_q, asm_d;
   logic [31:0]   s1_q, s2_q;
   logic          fv_q, fe_q;
   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
      .clk(clk), .reset(reset), .rx(rx),
      .data(rx_data), .byte_valid(byte_valid), .byte_err(byte_err)
   );
   assign asm_d = {asm_q[55:0], rx_data};
   // gap_q holds clocks elapsed since the last byte, so the error lands GAP_LIMIT clocks after it
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= F_IDLE;
         idx_q   <= '0;
         gap_q   <= '0;
         asm_q   <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         fv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         fv_q <= 1'b0;
         fe_q <= 1'b0;
         case (state_q)
            F_IDLE: if (byte_err) begin
               state_q <= F_ERROR;
               fe_q    <= 1'b1;
               idx_q   <= '0;
               asm_q   <= '0;
            end else if (byte_valid) begin
               asm_q   <= {56'd0, rx_data};
               idx_q   <= IW'(1);
               gap_q   <= GW'(1);
               state_q <= F_COLLECT;
            end
            F_COLLECT: if (byte_err || (!byte_valid && gap_q == GW'(GAP_LIMIT - 1))) begin
               state_q <= F_ERROR;
               fe_q    <= 1'b1;
               idx_q   <= '0;
               asm_q   <= '0;
            end else if (byte_valid) begin
               asm_q <= asm_d;
               gap_q <= GW'(1);
               if (idx_q == IW'(FRAME_BYTES - 1)) begin
                  s1_q    <= asm_d[63:32];
                  s2_q    <= asm_d[31:0];
                  fv_q    <= 1'b1;
                  idx_q   <= '0;
                  state_q <= F_IDLE;
               end else idx_q <= idx_q + 1'b1;
            end else gap_q <= gap_q + 1'b1;
            default: state_q <= F_IDLE;
         endcase
      end
   end
   assign sensor1_data = s1_q;
   assign sensor2_data = s2_q;
   assign frame_valid  = fv_q;
   assign frame_error  = fe_q;
   assign debug_state  = state_q;
endmodule
